// File: rtl/neuron_input_sequencer.sv
// Buffers N_IN samples, feeds them one per cycle to a neuron, waits SETTLE
// cycles, then captures the neuron output and pulses done.
module neuron_input_sequencer #(
    parameter int I_W    = 12,
    parameter int O_W    = 23,
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [1:0]     wr_addr,
    input  logic [I_W-1:0] wr_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [O_W-1:0] result,
    output logic           nrn_rst,
    output logic [I_W-1:0] nrn_in_data,
    input  logic [O_W-1:0] nrn_out_data
);

    localparam int IDX_W  = $clog2(N_IN + 1);
    localparam int WCNT_W = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IN - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        CAPT = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wcnt_nxt;
    logic [I_W-1:0]      sample_buf [N_IN];
    logic                wr_ok;

    // Out-of-range addresses and writes while an inference runs are dropped.
    assign wr_ok = wr_en && (state == IDLE) && (int'(wr_addr) < N_IN);

    // Sample buffer storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                sample_buf[i] <= '0;
            end
        end else if (wr_ok) begin
            sample_buf[wr_addr] <= wr_data;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state logic; counters hold outside the state that advances them.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FEED;
                    idx_nxt   = '0;
                    wcnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FEED: begin
                if (idx == IDX_LAST) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            WAIT: begin
                if (wcnt == WCNT_LAST) begin
                    state_nxt = CAPT;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            CAPT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result capture and the one-cycle done pulse on leaving CAPT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            done   <= 1'b0;
        end else if (state == CAPT) begin
            result <= nrn_out_data;
            done   <= 1'b1;
        end else begin
            done   <= 1'b0;
        end
    end

    // Sample presented to the neuron; driven from registers only.
    always_comb begin
        nrn_in_data = '0;
        if ((state == FEED) && (int'(idx) < N_IN)) begin
            nrn_in_data = sample_buf[idx];
        end else begin
            nrn_in_data = '0;
        end
    end

    // The neuron is held in clear whenever idle, so its index tracks idx.
    assign busy    = (state != IDLE);
    assign nrn_rst = (state == IDLE);

endmodule

// File: tb/tb_neuron_input_sequencer.sv
// Directed, table-driven bench for neuron_input_sequencer at default parameters.
module tb_neuron_input_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [11:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [22:0] result;
    logic        nrn_rst;
    logic [11:0] nrn_in_data;
    logic [22:0] nrn_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_input_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .nrn_rst      (nrn_rst),
        .nrn_in_data  (nrn_in_data),
        .nrn_out_data (nrn_out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [11:0] wd;
        logic        st;
        logic [22:0] nod;
        logic        e_busy;
        logic        e_done;
        logic        e_nrst;
        logic [11:0] e_in;
        logic [22:0] e_res;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_busy, input logic e_done,
                           input logic e_nrst, input logic [11:0] e_in, input logic [22:0] e_res);
        chk({tag, ".busy"},    32'(busy),        32'(e_busy));
        chk({tag, ".done"},    32'(done),        32'(e_done));
        chk({tag, ".nrn_rst"}, 32'(nrn_rst),     32'(e_nrst));
        chk({tag, ".nrn_in"},  32'(nrn_in_data), 32'(e_in));
        chk({tag, ".result"},  32'(result),      32'(e_res));
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [11:0] wd,
                                input logic st, input logic [22:0] nod, input logic e_busy,
                                input logic e_done, input logic e_nrst, input logic [11:0] e_in,
                                input logic [22:0] e_res);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.nod = nod;
        v.e_busy = e_busy; v.e_done = e_done; v.e_nrst = e_nrst; v.e_in = e_in; v.e_res = e_res;
        return v;
    endfunction

    initial begin
        logic [22:0] nod_v;

        // Table: inputs held for one cycle, expectations sampled after that edge.
        // Load buffer, then an out-of-range write (ignored).
        vq.push_back(mk(1'b1, 2'd0, 12'h101, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h0));
        vq.push_back(mk(1'b1, 2'd1, 12'h202, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h0));
        vq.push_back(mk(1'b1, 2'd2, 12'h303, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h0));
        vq.push_back(mk(1'b1, 2'd3, 12'hABC, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h0));
        // Inference 1: start at S, write while busy at S+1, re-start at S+2.
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b1, 23'h7, 1'b1, 1'b0, 1'b0, 12'h101, 23'h0));
        vq.push_back(mk(1'b1, 2'd1, 12'hFFF, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h202, 23'h0));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b1, 23'h7, 1'b1, 1'b0, 1'b0, 12'h303, 23'h0));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h0));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h0));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h0));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h001234, 1'b0, 1'b1, 1'b1, 12'h000, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h001234));
        // Inference 2: buffer must still hold 0x202 at element 1.
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b1, 23'h7, 1'b1, 1'b0, 1'b0, 12'h101, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h202, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h303, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h001234));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h00ABCD, 1'b0, 1'b1, 1'b1, 12'h000, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h00ABCD));
        // Inference 3: write and start in the same cycle; full-scale result.
        vq.push_back(mk(1'b1, 2'd0, 12'h055, 1'b1, 23'h7, 1'b1, 1'b0, 1'b0, 12'h055, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h202, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h303, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b1, 1'b0, 1'b0, 12'h000, 23'h00ABCD));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7FFFFF, 1'b0, 1'b1, 1'b1, 12'h000, 23'h7FFFFF));
        vq.push_back(mk(1'b0, 2'd0, 12'h000, 1'b0, 23'h7, 1'b0, 1'b0, 1'b1, 12'h000, 23'h7FFFFF));

        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_addr      = 2'd0;
        wr_data      = 12'h000;
        start        = 1'b0;
        nrn_out_data = 23'h0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b1, 12'h000, 23'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            wr_en        = vq[i].we;
            wr_addr      = vq[i].wa;
            wr_data      = vq[i].wd;
            start        = vq[i].st;
            nrn_out_data = vq[i].nod;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].e_busy, vq[i].e_done, vq[i].e_nrst,
                    vq[i].e_in, vq[i].e_res);
        end

        // Reset during FEED element 1 aborts and clears buffer and result.
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b1;
        nrn_out_data = 23'h7;
        @(posedge clk);
        #1;
        chk("abort.elem0", 32'(nrn_in_data), 32'h055);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.elem1", 32'(nrn_in_data), 32'h202);
        #2;
        rst = 1'b1;
        #1;
        chk_all("abort.rst", 1'b0, 1'b0, 1'b1, 12'h000, 23'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("abort.no_done", 32'(done), 32'h0);
            chk("abort.result0", 32'(result), 32'h0);
        end

        // Fresh inference after reset feeds the zeroed buffer.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start        = (k == 0);
            nrn_out_data = (k == 6) ? 23'h000321 : 23'h7;
            @(posedge clk);
            #1;
            chk("post_rst.nrn_in", 32'(nrn_in_data), 32'h0);
            chk("post_rst.busy", 32'(busy), 32'(k < 6));
            chk("post_rst.nrn_rst", 32'(nrn_rst), 32'(k == 6));
            chk("post_rst.done", 32'(done), 32'(k == 6));
            if (k == 6) begin
                chk("post_rst.result", 32'(result), 32'h000321);
            end
        end

        // start held high: back-to-back inferences, done every 7 cycles.
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            start        = 1'b1;
            nod_v        = 23'(32'h100 + c);
            nrn_out_data = nod_v;
            @(posedge clk);
            #1;
            chk("b2b.done", 32'(done), 32'((c % 7) == 6));
            chk("b2b.busy", 32'(busy), 32'((c % 7) != 6));
            if ((c % 7) == 6) begin
                chk("b2b.result", 32'(result), 32'(nod_v));
            end
        end
        @(negedge clk);
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
